// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the word-serial adder-subtractor.
package addsub_pkg;

  typedef enum logic {
    FIRST = 1'b0,
    BUSY  = 1'b1
  } addsub_state_e;

  // Word-counter width; a single-word configuration still needs one bit.
  function automatic int cnt_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  // Prefix-tree depth for a given word width.
  function automatic int tree_levels(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/addsub_serial_addsubc.sv
// Combinational add/subtract of one word with a selectable prefix-carry network.
// SUB=1 computes A-B-CI and reports CO as a borrow.
module AddSubC
  import addsub_pkg::*;
#(
  parameter int width = 8,
  parameter int speed = 2
) (
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic [width-1:0] S,
  output logic             CO
);

  localparam int LEVELS = tree_levels(width);

  // Subtraction is A + ~B + ~CI; the raw carry-out is then the inverse of the borrow.
  // NOTE: combinational blocks use blocking '=' and assign every variable before it is read,
  // so no storage (latch) is inferred.
  always_comb begin
    logic [width-1:0] b_x;
    logic [width-1:0] p;
    logic [width-1:0] gg;
    logic [width-1:0] pp;
    logic             cin;
    int               j;

    cin = CI ^ SUB;
    b_x = B ^ {width{SUB}};
    p   = A ^ b_x;
    gg  = A & b_x;
    gg[0] = gg[0] | (p[0] & cin);
    pp  = p;

    if (speed == 0) begin
      for (int i = 1; i < width; i++) begin
        gg[i] = gg[i] | (pp[i] & gg[i-1]);
      end
    end else if (speed == 1) begin
      for (int l = 0; l < LEVELS; l++) begin
        for (int i = 0; i < width; i++) begin
          if (((i + 1) % (1 << (l + 1))) == 0) begin
            j = i - (1 << l);
            gg[i] = gg[i] | (pp[i] & gg[j]);
            pp[i] = pp[i] & pp[j];
          end
        end
      end
      for (int d = LEVELS - 2; d >= 0; d--) begin
        for (int i = 0; i < width; i++) begin
          if ((((i + 1) % (1 << (d + 1))) == (1 << d)) && (i >= 3 * (1 << d) - 1)) begin
            j = i - (1 << d);
            gg[i] = gg[i] | (pp[i] & gg[j]);
            pp[i] = pp[i] & pp[j];
          end
        end
      end
    end else begin
      for (int l = 0; l < LEVELS; l++) begin
        for (int i = 0; i < width; i++) begin
          if (((i >> l) & 1) == 1) begin
            j = ((i >> l) << l) - 1;
            gg[i] = gg[i] | (pp[i] & gg[j]);
            pp[i] = pp[i] & pp[j];
          end
        end
      end
    end

    S  = p ^ {gg[width-2:0], cin};
    CO = gg[width-1] ^ SUB;
  end

endmodule

// File: rtl/addsub_serial.sv
// Word-serial multi-word adder-subtractor: LS word first, carry/borrow chained
// through a register, one output register stage with valid/ready on both sides.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int width = 8,
  parameter int words = 4,
  parameter int speed = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  input  logic             IN_LAST,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [width-1:0] S,
  output logic             OUT_LAST,
  output logic             CO,
  output logic             OV
);

  localparam int CW = cnt_width(words);
  localparam logic [CW-1:0] CNT_MAX = CW'(words - 1);

  addsub_state_e    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             out_valid_q, out_valid_d;
  logic [width-1:0] s_q, s_d;
  logic             out_last_q, out_last_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;

  logic             acc;
  logic             last;
  logic             ci_eff;
  logic             sub_eff;
  logic [width-1:0] add_s;
  logic             add_co;

  assign IN_READY = !RST && (!out_valid_q || OUT_READY);
  assign acc      = IN_VALID && IN_READY;
  assign ci_eff   = (state_q == FIRST) ? CI  : carry_q;
  assign sub_eff  = (state_q == FIRST) ? SUB : sub_q;
  assign last     = IN_LAST || (cnt_q == CNT_MAX);

  AddSubC #(
    .width(width),
    .speed(speed)
  ) u_addsubc (
    .A  (A),
    .B  (B),
    .CI (ci_eff),
    .SUB(sub_eff),
    .S  (add_s),
    .CO (add_co)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    out_valid_d = out_valid_q;
    s_d         = s_q;
    out_last_d  = out_last_q;
    co_d        = co_q;
    ov_d        = ov_q;

    if (acc) begin
      sub_d       = sub_eff;
      carry_d     = add_co;
      out_valid_d = 1'b1;
      s_d         = add_s;
      out_last_d  = last;
      co_d        = last && add_co;
      ov_d        = last && (A[width-1] == (B[width-1] ^ sub_eff)) &&
                    (add_s[width-1] != A[width-1]);
      if (last) begin
        state_d = FIRST;
        cnt_d   = '0;
      end else begin
        state_d = BUSY;
        cnt_d   = cnt_q + 1'b1;
      end
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= FIRST;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      out_last_q  <= 1'b0;
      co_q        <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      out_last_q  <= out_last_d;
      co_q        <= co_d;
      ov_q        <= ov_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign S         = s_q;
  assign OUT_LAST  = out_last_q;
  assign CO        = co_q;
  assign OV        = ov_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench: three instances (speed 0/1/2) share stimulus; each has its
// own expected-result queue popped by a monitor on every output handshake.
module tb_addsub_serial;

  localparam int NI = 3;

  typedef struct packed {
    logic [7:0] s;
    logic       last;
    logic       co;
    logic       ov;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       ci;
  logic       sub;
  logic       in_last;
  logic       out_ready;

  logic       in_ready  [NI];
  logic       out_valid [NI];
  logic [7:0] s_o       [NI];
  logic       out_last  [NI];
  logic       co_o      [NI];
  logic       ov_o      [NI];

  exp_t sb [NI][$];
  int   checks = 0;
  int   errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    addsub_serial #(.width(8), .words(4), .speed(g)) dut (
      .CLK      (clk),
      .RST      (rst),
      .IN_VALID (in_valid),
      .IN_READY (in_ready[g]),
      .A        (a),
      .B        (b),
      .CI       (ci),
      .SUB      (sub),
      .IN_LAST  (in_last),
      .OUT_VALID(out_valid[g]),
      .OUT_READY(out_ready),
      .S        (s_o[g]),
      .OUT_LAST (out_last[g]),
      .CO       (co_o[g]),
      .OV       (ov_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s speed=%0d got=%0h expected=%0h", name, k, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (out_valid[k] && out_ready) begin
        if (sb[k].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output speed=%0d got S=%0h expected none", k, s_o[k]);
        end else begin
          exp_t e;
          e = sb[k].pop_front();
          check("S", k, 32'(s_o[k]), 32'(e.s));
          check("OUT_LAST", k, 32'(out_last[k]), 32'(e.last));
          check("CO", k, 32'(co_o[k]), 32'(e.co));
          check("OV", k, 32'(ov_o[k]), 32'(e.ov));
        end
      end
    end
  end

  function automatic logic all_ready();
    logic r;
    r = 1'b1;
    for (int k = 0; k < NI; k++) r = r & in_ready[k];
    return r;
  endfunction

  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tci,
                      input logic tsub, input logic tlast, input logic [7:0] es,
                      input logic el, input logic eco, input logic eov);
    int n;
    exp_t e;
    n = 0;
    a = ta; b = tb; ci = tci; sub = tsub; in_last = tlast;
    in_valid = 1'b1;
    @(negedge clk);
    while (!all_ready() && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!all_ready()) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got IN_READY=0 expected 1 within 50 cycles");
    end else begin
      e = '{s: es, last: el, co: eco, ov: eov};
      for (int k = 0; k < NI; k++) sb[k].push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("rst_OUT_VALID", k, 32'(out_valid[k]), 0);
      check("rst_S", k, 32'(s_o[k]), 0);
      check("rst_OUT_LAST", k, 32'(out_last[k]), 0);
      check("rst_CO", k, 32'(co_o[k]), 0);
      check("rst_OV", k, 32'(ov_o[k]), 0);
      check("rst_IN_READY", k, 32'(in_ready[k]), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-word add
    send(8'hF0, 8'h20, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0);

    // Two-word subtract 0x0100 - 0x0001; SUB toggled on word 1 must be ignored
    send(8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    send(8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);

    // Signed overflow
    send(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1);

    // Backpressure on a 3-word add
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(8'hFF, 8'h02, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
    fork
      begin
        send(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h47, 1'b1, 1'b0, 1'b0);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          for (int k = 0; k < NI; k++) begin
            check("stall_IN_READY", k, 32'(in_ready[k]), 0);
            check("stall_OUT_VALID", k, 32'(out_valid[k]), 1);
            check("stall_S", k, 32'(s_o[k]), 32'h01);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join

    // Forced termination after 4 words; word 5 starts a new op with its own CI/SUB
    send(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
    send(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
    send(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
    send(8'h7F, 8'h00, 1'b0, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1);
    send(8'h10, 8'h03, 1'b1, 1'b1, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b0);
    send(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a 3-word subtract (borrow pending)
    send(8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    send(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) check("mid_rst_IN_READY", k, 32'(in_ready[k]), 0);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("mid_rst_OUT_VALID", k, 32'(out_valid[k]), 0);
      check("mid_rst_IN_READY2", k, 32'(in_ready[k]), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h05, 8'h03, 1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);

    n = 0;
    while (n < 50 && (sb[0].size() + sb[1].size() + sb[2].size()) != 0) begin
      n++;
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    for (int k = 0; k < NI; k++) check("sb_drained", k, 32'(sb[k].size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Word-serial multi-word adder-subtractor that streams wide operands through one `AddSubC` instance, one `width`-bit word per cycle, least significant word first. The inter-word carry/borrow is kept in a register, so arbitrarily long operations (up to `words` words) use one narrow prefix adder. It sits between an operand-fetch stream and a result-writeback stream, with valid/ready handshakes on both sides and one output register stage.

## Interface
- `width`, 8: word width in bits, ≥ 2.
- `words`, 4: maximum number of words per operation, ≥ 1. Sets the word-counter width, `$clog2(words)` (minimum 1).
- `speed`, 2: passed unchanged to `AddSubC` (0 serial, 1 Brent-Kung, 2 Sklansky).

Ports:
- `CLK`  in  1  clock; all logic is rising-edge.
- `RST`  in  1  synchronous reset, active-high.
- `IN_VALID`  in  1  input word valid.
- `IN_READY`  out  1  input word accepted when `IN_VALID && IN_READY`.
- `A`  in  width  operand A word.
- `B`  in  width  operand B word.
- `CI`  in  1  carry-in (added, or subtracted when `SUB`=1); sampled on the first word only.
- `SUB`  in  1  subtract enable; sampled on the first word only.
- `IN_LAST`  in  1  marks the most significant word.
- `OUT_VALID`  out  1  result word valid.
- `OUT_READY`  in  1  result word consumed when `OUT_VALID && OUT_READY`.
- `S`  out  width  result word.
- `OUT_LAST`  out  1  result word is the final word of the operation.
- `CO`  out  1  final carry-out (borrow when subtracting); meaningful only with `OUT_LAST`, else 0.
- `OV`  out  1  two's-complement overflow of the whole operation; meaningful only with `OUT_LAST`, else 0.

## Operation
- States:
  - FIRST: the next accepted word starts an operation.
  - BUSY: mid-operation.
- Accept: `acc = IN_VALID && IN_READY`.
- `IN_READY = !RST && (!OUT_VALID || OUT_READY)`.
- Adder inputs:
  - The adder sees `A`, `B`, `CI_eff` and `SUB_eff`.
  - In FIRST: `CI_eff = CI` and `SUB_eff = SUB`. On `acc`, `SUB` is latched into `sub_q`.
  - In BUSY: `CI_eff = carry_q` and `SUB_eff = sub_q`. The `CI` and `SUB` inputs are ignored.
- On `acc`:
  - `carry_q` takes `AddSubC.CO`. This is a borrow when subtracting, so it chains directly into the next `CI_eff`.
  - The word counter increments.
  - The sum is registered into `S`.
- Last word: `last = IN_LAST || (cnt == words-1)`.
  - When `words` is reached without `IN_LAST`, the operation is force-terminated.
  - On a last accept: `OUT_LAST`=1, `CO` = adder CO, `OV` = (A[msb] == (B[msb]^SUB_eff)) && (S[msb] != A[msb]).
  - The state returns to FIRST and `cnt`=0. `carry_q` is don't-care in FIRST.
  - On a non-last accept the state goes to BUSY.
- Output register: loads on `acc`. `OUT_VALID` clears on `OUT_READY` without a new `acc`.
- Simultaneous consume and accept: the new word replaces the old one with no bubble, giving full throughput.
- `IN_VALID` low in BUSY: the operation stalls indefinitely with state, carry and counter held.

## Timing
- Latency is 1 cycle from input accept to `OUT_VALID`. Throughput is 1 word/cycle when `OUT_READY`=1.
- Combinational paths:
  - `IN_READY` depends on `OUT_VALID`, `OUT_READY` and `RST`.
  - There is no combinational path from input data to output.
- While `OUT_VALID`=1 and `OUT_READY`=0, the values of `S`, `OUT_LAST`, `CO` and `OV` are held stable.
- Reset values (registered, one cycle after `RST` is sampled high):
  - `OUT_VALID`=0, `S`=0, `OUT_LAST`=0, `CO`=0, `OV`=0.
  - State FIRST, `cnt`=0, `carry_q`=0, `sub_q`=0.
- Reset mid-operation aborts it. Partially delivered words are not retracted, and the next accepted word starts a new operation.
- `IN_READY`=0 in every cycle where `RST`=1.

## Structure
- Package `addsub_pkg`:
  - `typedef enum logic {FIRST, BUSY} addsub_state_e`.
  - Helper constant for the counter width, `$clog2(words)` (minimum 1).
- Sub-module: one `AddSubC #(width, speed)` instance computes each word. No other sub-modules; the control and output register are inline.

## Test plan
All scenarios use `width`=8, `words`=4, `speed`=2, and are repeated for `speed` 0 and 1.
- Single-word add: A=0xF0, B=0x20, CI=1, SUB=0, IN_LAST=1 → next cycle S=0x11, CO=1, OV=0, OUT_LAST=1.
- Two-word subtract 0x0100−0x0001:
  - Word 0 (A=0x00, B=0x01, SUB=1, CI=0) → S=0xFF, OUT_LAST=0.
  - Word 1 (A=0x01, B=0x00, IN_LAST=1, SUB input toggled to 0) → S=0x00, CO=0, OV=0. This confirms `SUB` is latched.
- Signed overflow: A=0x7F, B=0x01, SUB=0, CI=0, IN_LAST=1 → S=0x80, OV=1, CO=0.
- Backpressure: 3-word add with OUT_READY=0 for 3 cycles after the first output → IN_READY=0, S stable. On release, words arrive in order and the carries are correct against a reference model.
- Forced termination: 5 words with IN_LAST=0 throughout → word 4 has OUT_LAST=1. Word 5 starts a new operation using its own CI and SUB.
- Reset mid-operation: RST pulsed after word 1 of a 3-word subtract → OUT_VALID=0 and IN_READY=0 during reset. The next word behaves as a first word (A=0x05, B=0x03, SUB=1, CI=0, IN_LAST=1 → S=0x02, CO=0).
